// File: rtl/riscv_pkg.sv
// Shared types for the memory stage: funct3 access sizes and the LSU state encoding.
package riscv_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        MEM_B  = 3'b000,
        MEM_H  = 3'b001,
        MEM_W  = 3'b010,
        MEM_BU = 3'b100,
        MEM_HU = 3'b101
    } mem_size_e;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_WAIT = 2'd2,
        LSU_DONE = 2'd3
    } lsu_state_e;

    // Unused size encodings are treated as word accesses.
    function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] off);
        logic mis;
        case (size)
            MEM_B, MEM_BU: mis = 1'b0;
            MEM_H, MEM_HU: mis = off[0];
            default:       mis = (off != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_data_align.sv
// Pure combinational lane logic: byte enables and store replication on the way out,
// byte/half extraction with sign or zero extension on the way back.
module lsu_data_align
    import riscv_pkg::*;
(
    input  logic [2:0]      size_i,
    input  logic [1:0]      off_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [XLEN-1:0] rdata_i,
    output logic [3:0]      be_o,
    output logic [XLEN-1:0] wdata_o,
    output logic [XLEN-1:0] rdata_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = rdata_i[{off_i, 3'b000} +: 8];
        half_v = rdata_i[{off_i[1], 4'b0000} +: 16];
    end

    always_comb begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
        rdata_o = rdata_i;
        case (size_i)
            MEM_B: begin
                be_o    = 4'b0001 << off_i;
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = {{24{byte_v[7]}}, byte_v};
            end
            MEM_BU: begin
                be_o    = 4'b0001 << off_i;
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = {24'h0, byte_v};
            end
            MEM_H: begin
                be_o    = 4'b0011 << off_i;
                wdata_o = {2{wdata_i[15:0]}};
                rdata_o = {{16{half_v[15]}}, half_v};
            end
            MEM_HU: begin
                be_o    = 4'b0011 << off_i;
                wdata_o = {2{wdata_i[15:0]}};
                rdata_o = {16'h0, half_v};
            end
            default: begin
                be_o    = 4'b1111;
                wdata_o = wdata_i;
                rdata_o = rdata_i;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory stage: runs one request/grant/response bus transaction per LOAD/STORE,
// stalling the core until it completes, is rejected as misaligned, or times out.
module load_store_unit
    import riscv_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            req_i,
    input  logic            we_i,
    input  logic [2:0]      size_i,
    input  logic [XLEN-1:0] addr_i,
    input  logic [XLEN-1:0] wdata_i,
    output logic [XLEN-1:0] rdata_o,
    output logic            done_o,
    output logic            stall_o,
    output logic            misaligned_o,
    output logic            bus_err_o,
    output logic            mem_req_o,
    input  logic            mem_gnt_i,
    output logic            mem_we_o,
    output logic [3:0]      mem_be_o,
    output logic [XLEN-1:0] mem_addr_o,
    output logic [XLEN-1:0] mem_wdata_o,
    input  logic            mem_rvalid_i,
    input  logic [XLEN-1:0] mem_rdata_i,
    input  logic            mem_err_i,
    output lsu_state_e      state_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    lsu_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic            mis_q, mis_d;
    logic            err_q, err_d;

    logic            we_q;
    logic [2:0]      size_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;

    logic            accept;
    logic            timeout;
    logic            in_req;
    logic            in_done;
    logic [3:0]      be;
    logic [XLEN-1:0] wdata_rep;
    logic [XLEN-1:0] rdata_ext;

    lsu_data_align u_align (
        .size_i  (size_q),
        .off_i   (addr_q[1:0]),
        .wdata_i (wdata_q),
        .rdata_i (mem_rdata_i),
        .be_o    (be),
        .wdata_o (wdata_rep),
        .rdata_o (rdata_ext)
    );

    assign accept  = (state_q == LSU_IDLE) && req_i;
    assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign in_req  = (state_q == LSU_REQ);
    assign in_done = (state_q == LSU_DONE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        mis_d   = mis_q;
        err_d   = err_q;
        case (state_q)
            LSU_IDLE: begin
                if (req_i) begin
                    mis_d = is_misaligned(size_i, addr_i[1:0]);
                    err_d = 1'b0;
                    cnt_d = '0;
                    state_d = is_misaligned(size_i, addr_i[1:0]) ? LSU_DONE : LSU_REQ;
                end
            end
            LSU_REQ: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (timeout) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = LSU_DONE;
                end else if (mem_gnt_i) begin
                    state_d = LSU_WAIT;
                end
            end
            LSU_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                // A response arriving on the last allowed cycle still counts as completion.
                if (mem_rvalid_i) begin
                    err_d   = mem_err_i;
                    rdata_d = mem_err_i ? '0 : rdata_ext;
                    state_d = LSU_DONE;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = LSU_DONE;
                end
            end
            LSU_DONE: begin
                state_d = LSU_IDLE;
            end
            default: begin
                state_d = LSU_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= LSU_IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            mis_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            mis_q   <= mis_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            we_q    <= 1'b0;
            size_q  <= 3'b000;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            we_q    <= we_i;
            size_q  <= size_i;
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
        end
    end

    // Bus fields are driven only while requesting so they read as zero otherwise.
    assign mem_req_o   = in_req;
    assign mem_we_o    = in_req & we_q;
    assign mem_be_o    = in_req ? be : 4'b0000;
    assign mem_addr_o  = in_req ? {addr_q[XLEN-1:2], 2'b00} : '0;
    assign mem_wdata_o = in_req ? wdata_rep : '0;

    assign done_o       = in_done;
    assign misaligned_o = in_done & mis_q;
    assign bus_err_o    = in_done & err_q;
    assign rdata_o      = rdata_q;
    assign stall_o      = req_i & ~in_done;
    assign state_o      = state_q;

endmodule
